uart_mem_responder: RTL and testbench

UART_MEM_RESPONDER -- requirements
Module: uart_mem_responder

---
 rtl/uart_resp_pkg.sv | 19 +
 rtl/uart_mem_responder.sv | 155 +++++++++++++++
 tb/tb_uart_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_resp_pkg.sv
// Shared FSM state encoding and host-link byte codes for uart_mem_responder.
// Pure definitions; no logic and no latency.
package uart_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        MEM,
        TX_START,
        TX_WAIT
    } state_e;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

endpackage

// File: rtl/uart_mem_responder.sv
// UART host-link responder: decodes 9-byte write / 5-byte read packets into one bus access, replies ACK/NAK/rdata.
// Bus request starts the cycle after the last packet byte; first tx byte the cycle after ack; rx bytes arriving while busy are dropped.
module uart_mem_responder
    import uart_resp_pkg::*;
#(
    parameter int TIMEOUT_CCS = 21700
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_byte_o,
    output logic        tx_valid_o,
    input  logic        tx_done_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        busy_o,
    output logic        drop_o
);

    localparam int            TW       = $clog2(TIMEOUT_CCS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CCS - 1);

    state_e        state_q;
    logic [1:0]    cnt_q;
    logic [1:0]    rem_q;
    logic [TW-1:0] timer_q;
    logic [23:0]   resp_q;
    logic [7:0]    tx_byte_q;
    logic          tx_valid_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          drop_q;

    logic          rx_phase_d;
    logic          timeout_d;

    assign rx_phase_d = (state_q == ADDR) || (state_q == WDATA);
    // timer_q counts idle cycles since the last accepted byte; expiry beats a coincident byte
    assign timeout_d  = rx_phase_d && (timer_q == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            rem_q      <= 2'd0;
            timer_q    <= '0;
            resp_q     <= 24'd0;
            tx_byte_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            drop_q     <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            drop_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_valid_i) begin
                        if (rx_byte_i == CMD_WR || rx_byte_i == CMD_RD) begin
                            mem_we_q <= (rx_byte_i == CMD_WR);
                            cnt_q    <= 2'd0;
                            timer_q  <= '0;
                            state_q  <= ADDR;
                        end else begin
                            tx_byte_q  <= RSP_NAK;
                            tx_valid_q <= 1'b1;
                            rem_q      <= 2'd0;
                            state_q    <= TX_START;
                        end
                    end
                end
                ADDR, WDATA: begin
                    if (timeout_d) begin
                        cnt_q   <= 2'd0;
                        drop_q  <= rx_valid_i;
                        state_q <= IDLE;
                    end else if (rx_valid_i) begin
                        timer_q <= '0;
                        // 2-bit counter wraps to 0 after the 4th byte of each field
                        cnt_q   <= cnt_q + 2'd1;
                        if (state_q == ADDR) begin
                            addr_q[{cnt_q, 3'b000} +: 8] <= rx_byte_i;
                        end else begin
                            wdata_q[{cnt_q, 3'b000} +: 8] <= rx_byte_i;
                        end
                        if (cnt_q == 2'd3) begin
                            if (state_q == ADDR && mem_we_q) begin
                                state_q <= WDATA;
                            end else begin
                                mem_req_q <= 1'b1;
                                state_q   <= MEM;
                            end
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                MEM: begin
                    drop_q <= rx_valid_i;
                    if (mem_ack_i) begin
                        mem_req_q  <= 1'b0;
                        tx_valid_q <= 1'b1;
                        state_q    <= TX_START;
                        if (mem_we_q) begin
                            tx_byte_q <= RSP_ACK;
                            rem_q     <= 2'd0;
                        end else begin
                            tx_byte_q <= mem_rdata_i[7:0];
                            resp_q    <= mem_rdata_i[31:8];
                            rem_q     <= 2'd3;
                        end
                    end
                end
                TX_START: begin
                    drop_q  <= rx_valid_i;
                    state_q <= TX_WAIT;
                end
                TX_WAIT: begin
                    drop_q <= rx_valid_i;
                    if (tx_done_i) begin
                        if (rem_q != 2'd0) begin
                            tx_byte_q  <= resp_q[7:0];
                            resp_q     <= {8'd0, resp_q[23:8]};
                            rem_q      <= rem_q - 2'd1;
                            tx_valid_q <= 1'b1;
                            state_q    <= TX_START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_byte_o   = tx_byte_q;
    assign tx_valid_o  = tx_valid_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != IDLE);
    assign drop_o      = drop_q;

endmodule

// File: tb/tb_uart_mem_responder.sv
// Directed bench for uart_mem_responder: scoreboard queues hold expected bus accesses and tx bytes,
// popped by a bus responder model and a uart_tx model as the DUT produces them.
module tb_uart_mem_responder;

    localparam int TO = 40;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  rx_byte_i = 8'd0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  tx_byte_o;
    logic        tx_valid_o;
    logic        tx_done_i = 1'b0;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i = 32'd0;
    logic        mem_ack_i = 1'b0;
    logic        busy_o;
    logic        drop_o;

    uart_mem_responder #(.TIMEOUT_CCS(TO)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_byte_i  (rx_byte_i),
        .rx_valid_i (rx_valid_i),
        .tx_byte_o  (tx_byte_o),
        .tx_valid_o (tx_valid_o),
        .tx_done_i  (tx_done_i),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i  (mem_ack_i),
        .busy_o     (busy_o),
        .drop_o     (drop_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memx_t;

    logic [7:0]  exp_tx_q[$];
    memx_t       exp_mem_q[$];
    logic [31:0] rdata_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int tx_seen = 0;
    int mem_seen = 0;
    int drop_cnt = 0;
    bit mem_auto = 1'b1;
    bit stray_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // uart_tx model: scoreboard check on each start pulse, byte held, done pulse 4 cycles later
    initial begin
        logic [7:0] b;
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            tx_done_i = 1'b0;
            if (tx_valid_o) begin
                tx_seen++;
                e = (exp_tx_q.size() != 0) ? {24'd0, exp_tx_q.pop_front()} : 32'hFFFF_FFFF;
                check("tx_byte", {24'd0, tx_byte_o}, e);
                b = tx_byte_o;
                repeat (3) @(negedge clk_i);
                check("tx_hold", {24'd0, tx_byte_o}, {24'd0, b});
                check("tx_single_pulse", {31'd0, tx_valid_o}, 32'd0);
                tx_done_i = 1'b1;
            end
        end
    end

    // bus model: checks request fields, acks after 3 cycles
    initial begin
        memx_t e;
        forever begin
            @(negedge clk_i);
            mem_ack_i = stray_ack;
            if (mem_req_o && mem_auto) begin
                mem_seen++;
                if (exp_mem_q.size() != 0) e = exp_mem_q.pop_front();
                else begin e.we = 1'bx; e.addr = 'x; e.wdata = 'x; end
                check("mem_we", {31'd0, mem_we_o}, {31'd0, e.we});
                check("mem_addr", mem_addr_o, e.addr);
                if (e.we === 1'b1) check("mem_wdata", mem_wdata_o, e.wdata);
                repeat (3) begin
                    @(negedge clk_i);
                    check("mem_req_hold", {31'd0, mem_req_o}, 32'd1);
                    check("mem_addr_hold", mem_addr_o, e.addr);
                end
                mem_ack_i   = 1'b1;
                mem_rdata_i = (e.we === 1'b0 && rdata_q.size() != 0) ? rdata_q.pop_front() : 32'h0BAD_0BAD;
                @(negedge clk_i);
                mem_ack_i   = 1'b0;
                mem_rdata_i = 32'd0;
                check("mem_req_drop", {31'd0, mem_req_o}, 32'd0);
                check("tx_after_ack", {31'd0, tx_valid_o}, 32'd1);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (drop_o) drop_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        repeat (gap) @(negedge clk_i);
    endtask

    task automatic send_pkt(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input int gap);
        logic [31:0] a;
        logic [31:0] d;
        a = addr;
        d = data;
        send_byte(cmd, gap);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], (cmd == 8'h52 && i == 3) ? 0 : gap);
        if (cmd == 8'h57)
            for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], (i == 3) ? 0 : gap);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy_o || exp_tx_q.size() != 0) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        repeat (2) @(negedge clk_i);
        check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_txq_empty"}, exp_tx_q.size(), 32'd0);
    endtask

    initial begin
        int tx0;
        int mem0;
        int drop0;
        int n;
        memx_t m;

        repeat (3) @(negedge clk_i);
        check("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        check("rst_tx_byte", {24'd0, tx_byte_o}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_drop", {31'd0, drop_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // write
        m.we = 1'b1; m.addr = 32'h0000_0010; m.wdata = 32'hDEAD_BEEF;
        exp_mem_q.push_back(m);
        exp_tx_q.push_back(8'h06);
        send_pkt(8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 2);
        check("wr_req_next_cycle", {31'd0, mem_req_o}, 32'd1);
        wait_idle("wr");
        check("wr_one_req", mem_seen, 32'd1);
        check("wr_tx_count", tx_seen, 32'd1);

        // read
        m.we = 1'b0; m.addr = 32'h0000_0010; m.wdata = 32'd0;
        exp_mem_q.push_back(m);
        rdata_q.push_back(32'h1234_5678);
        exp_tx_q.push_back(8'h78); exp_tx_q.push_back(8'h56);
        exp_tx_q.push_back(8'h34); exp_tx_q.push_back(8'h12);
        send_pkt(8'h52, 32'h0000_0010, 32'd0, 1);
        check("rd_req_next_cycle", {31'd0, mem_req_o}, 32'd1);
        wait_idle("rd");
        check("rd_tx_count", tx_seen, 32'd5);

        // bad command
        mem0 = mem_seen;
        exp_tx_q.push_back(8'h15);
        send_byte(8'hA5, 0);
        check("nak_tx_next_cycle", {31'd0, tx_valid_o}, 32'd1);
        check("nak_no_req", {31'd0, mem_req_o}, 32'd0);
        wait_idle("nak");
        check("nak_no_mem", mem_seen, mem0);

        // timeout after partial packet, then a read with maximal legal gaps
        tx0 = tx_seen; mem0 = mem_seen;
        send_byte(8'h57, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        repeat (TO - 1) @(negedge clk_i);
        check("tmo_busy_before", {31'd0, busy_o}, 32'd1);
        @(negedge clk_i);
        check("tmo_busy_after", {31'd0, busy_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        check("tmo_no_mem", mem_seen, mem0);
        check("tmo_no_tx", tx_seen, tx0);
        m.we = 1'b0; m.addr = 32'h0000_1234; m.wdata = 32'd0;
        exp_mem_q.push_back(m);
        rdata_q.push_back(32'hCAFE_F00D);
        exp_tx_q.push_back(8'h0D); exp_tx_q.push_back(8'hF0);
        exp_tx_q.push_back(8'hFE); exp_tx_q.push_back(8'hCA);
        send_pkt(8'h52, 32'h0000_1234, 32'd0, TO - 2);
        check("reload_req", {31'd0, mem_req_o}, 32'd1);
        wait_idle("reload");

        // byte landing exactly on timeout expiry is dropped
        drop0 = drop_cnt;
        send_byte(8'h57, TO - 1);
        send_byte(8'h52, 0);
        check("tmo_coincide_idle", {31'd0, busy_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        check("tmo_coincide_drop", drop_cnt, drop0 + 1);
        check("tmo_coincide_still_idle", {31'd0, busy_o}, 32'd0);

        // overrun during TX_WAIT
        drop0 = drop_cnt;
        m.we = 1'b0; m.addr = 32'h0000_0020; m.wdata = 32'd0;
        exp_mem_q.push_back(m);
        rdata_q.push_back(32'hA1B2_C3D4);
        exp_tx_q.push_back(8'hD4); exp_tx_q.push_back(8'hC3);
        exp_tx_q.push_back(8'hB2); exp_tx_q.push_back(8'hA1);
        send_pkt(8'h52, 32'h0000_0020, 32'd0, 1);
        n = 0;
        while (!tx_valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("ovr_tx_seen", {31'd0, tx_valid_o}, 32'd1);
        @(negedge clk_i);
        send_byte(8'h52, 0);
        wait_idle("ovr");
        check("ovr_drop_once", drop_cnt, drop0 + 1);

        // reset while the bus request is pending; a later ack must be ignored
        mem_auto = 1'b0;
        tx0 = tx_seen;
        send_pkt(8'h57, 32'h0000_0040, 32'h1122_3344, 1);
        check("rstx_req_up", {31'd0, mem_req_o}, 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        check("rstx_req", {31'd0, mem_req_o}, 32'd0);
        check("rstx_we", {31'd0, mem_we_o}, 32'd0);
        check("rstx_addr", mem_addr_o, 32'd0);
        check("rstx_wdata", mem_wdata_o, 32'd0);
        check("rstx_busy", {31'd0, busy_o}, 32'd0);
        check("rstx_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        check("rstx_tx_byte", {24'd0, tx_byte_o}, 32'd0);
        stray_ack = 1'b1;
        repeat (3) @(negedge clk_i);
        stray_ack = 1'b0;
        repeat (6) @(negedge clk_i);
        check("rstx_no_tx", tx_seen, tx0);
        check("rstx_req_after_ack", {31'd0, mem_req_o}, 32'd0);
        check("rstx_busy_after_ack", {31'd0, busy_o}, 32'd0);
        mem_auto = 1'b1;

        // recovery write
        m.we = 1'b1; m.addr = 32'h0000_0044; m.wdata = 32'h5566_7788;
        exp_mem_q.push_back(m);
        exp_tx_q.push_back(8'h06);
        send_pkt(8'h57, 32'h0000_0044, 32'h5566_7788, 0);
        wait_idle("recover");
        check("memq_empty", exp_mem_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
